// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency valid-tagged pipeline among n_req requesters and steers results back by shadow tag.
// Optional PIPE_SHARE_ARB_ROUND_ROBIN_EN: rotating priority pointer; undefined gives fixed priority (requester 0 highest).
module pipe_share_arbiter #(
   parameter int n_req   = 4,
   parameter int width   = 8,
   parameter int latency = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           hold,
   input  logic [n_req-1:0]               req_vld,
   input  logic [n_req*width-1:0]         req_data,
   output logic [n_req-1:0]               req_rdy,
   output logic                           pipe_in_vld,
   output logic [width-1:0]               pipe_in_data,
   input  logic                           pipe_out_vld,
   input  logic [width-1:0]               pipe_out_data,
   output logic [n_req-1:0]               rsp_vld,
   output logic [width-1:0]               rsp_data,
   output logic [$clog2(latency+1)-1:0]   inflight,
   output logic                           err
);

   localparam int          IDW  = (n_req > 1) ? $clog2(n_req) : 1;
   localparam int          CW   = $clog2(latency + 1);
   localparam int unsigned NREQ = n_req;

   logic [IDW-1:0]     w_start;
   logic [n_req-1:0]   w_gnt;
   logic [IDW-1:0]     w_gnt_id;
   logic               w_found;
   logic               w_accept;
   int unsigned        w_idx;
   logic [IDW-1:0]     w_idx_id;

   logic [latency-1:0] r_tag_vld;
   logic [IDW-1:0]     r_tag_id [latency];
   logic               w_tag_vld_out;
   logic [IDW-1:0]     w_tag_id_out;

   logic [CW-1:0]      r_inflight;
   logic               r_err;

`ifdef PIPE_SHARE_ARB_ROUND_ROBIN_EN
   logic [IDW-1:0]     r_ptr;

   assign w_start = r_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_gnt_id == IDW'(n_req - 1)) ? '0 : w_gnt_id + 1'b1;
      end
   end
`else
   assign w_start = '0;
`endif

   // Scan from w_start upward, wrapping at n_req; hold suppresses the grant entirely.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_idx    = 0;
      w_idx_id = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_idx = int'(w_start) + i;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         w_idx_id = w_idx[IDW-1:0];
         if (!w_found && req_vld[w_idx_id]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx_id;
         end
      end
      if (hold) w_found = 1'b0;
      w_gnt = '0;
      if (w_found) w_gnt[w_gnt_id] = 1'b1;
   end

   assign w_accept    = |(req_vld & w_gnt);
   assign req_rdy     = w_gnt;
   assign pipe_in_vld = w_accept;

   always_comb begin
      pipe_in_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_accept && w_gnt[i]) pipe_in_data = req_data[i*width +: width];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_vld <= '0;
         for (int unsigned i = 0; i < latency; i++) r_tag_id[i] <= '0;
      end else begin
         r_tag_vld   <= {r_tag_vld[latency-2:0], w_accept};
         r_tag_id[0] <= w_gnt_id;
         for (int unsigned i = 1; i < latency; i++) r_tag_id[i] <= r_tag_id[i-1];
      end
   end

   assign w_tag_vld_out = r_tag_vld[latency-1];
   assign w_tag_id_out  = r_tag_id[latency-1];

   // A valid mismatch in either direction yields no response since both must agree.
   always_comb begin
      rsp_vld = '0;
      if (pipe_out_vld && w_tag_vld_out) rsp_vld[w_tag_id_out] = 1'b1;
   end

   assign rsp_data = pipe_out_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
         r_err      <= 1'b0;
      end else begin
         if (pipe_out_vld != w_tag_vld_out) r_err <= 1'b1;
         case ({w_accept, w_tag_vld_out})
            2'b10:   if (r_inflight != CW'(latency)) r_inflight <= r_inflight + 1'b1;
            2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign inflight = r_inflight;
   assign err      = r_err;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a behavioural 8-deep valid/data pipeline attached.
module tb_pipe_share_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 8;
`ifdef PIPE_SHARE_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           hold = 1'b0;
   logic [N-1:0]   req_vld = '0;
   logic [N*W-1:0] req_data = {8'h13, 8'h12, 8'h11, 8'h10};
   logic [N-1:0]   req_rdy;
   logic           pipe_in_vld;
   logic [W-1:0]   pipe_in_data;
   logic           pipe_out_vld;
   logic [W-1:0]   pipe_out_data;
   logic [N-1:0]   rsp_vld;
   logic [W-1:0]   rsp_data;
   logic [3:0]     inflight;
   logic           err;
   logic           force_vld = 1'b0;

   logic [LAT-1:0] p_vld;
   logic [W-1:0]   p_dat [LAT];

   int n_vec = 0;
   int n_err = 0;

   bit       sb_vld [0:31];
   int       sb_id  [0:31];

   always #5 clk = ~clk;

   pipe_share_arbiter #(.n_req(N), .width(W), .latency(LAT)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
      .pipe_in_vld(pipe_in_vld), .pipe_in_data(pipe_in_data),
      .pipe_out_vld(pipe_out_vld), .pipe_out_data(pipe_out_data),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data),
      .inflight(inflight), .err(err)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p_vld <= '0;
         for (int i = 0; i < LAT; i++) p_dat[i] <= '0;
      end else begin
         p_vld    <= {p_vld[LAT-2:0], pipe_in_vld};
         p_dat[0] <= pipe_in_data;
         for (int i = 1; i < LAT; i++) p_dat[i] <= p_dat[i-1];
      end
   end

   assign pipe_out_vld  = p_vld[LAT-1] | force_vld;
   assign pipe_out_data = p_dat[LAT-1];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; hold = 1'b0; req_vld = '0; force_vld = 1'b0;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      step; step;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin sb_vld[i] = 1'b0; sb_id[i] = 0; end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_vld = 4'b1010;
      step;
      #1;
      n_vec++; if (inflight !== 4'd0) begin n_err++; $display("FAIL reset_inflight got %0d want 0", inflight); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
      n_vec++; if (rsp_vld !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_vld got %b want 0000", rsp_vld); end
      n_vec++; if (req_rdy !== 4'b0010) begin n_err++; $display("FAIL reset_req_rdy got %b want 0010", req_rdy); end
      do_reset;
   endtask

   task automatic test_single_issue;
      logic [N-1:0] exp_rsp;
      do_reset;
      for (int c = 0; c < 10; c++) step;
      req_data[2*W +: W] = 8'hA5;
      req_vld = 4'b0100;
      #1;
      n_vec++; if (req_rdy !== 4'b0100) begin n_err++; $display("FAIL single_rdy got %b want 0100", req_rdy); end
      n_vec++; if (pipe_in_vld !== 1'b1 || pipe_in_data !== 8'hA5) begin n_err++; $display("FAIL single_pipe_in got %b/%h want 1/a5", pipe_in_vld, pipe_in_data); end
      step;
      req_vld = '0;
      for (int k = 1; k <= LAT; k++) begin
         #1;
         exp_rsp = (k == LAT) ? 4'b0100 : 4'b0000;
         n_vec++; if (inflight !== 4'd1) begin n_err++; $display("FAIL single_inflight k=%0d got %0d want 1", k, inflight); end
         n_vec++; if (rsp_vld !== exp_rsp) begin n_err++; $display("FAIL single_rsp_vld k=%0d got %b want %b", k, rsp_vld, exp_rsp); end
         if (k == LAT) begin
            n_vec++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL single_rsp_data got %h want a5", rsp_data); end
         end
         step;
      end
      #1;
      n_vec++; if (inflight !== 4'd0 || rsp_vld !== 4'b0000) begin n_err++; $display("FAIL single_drain got %0d/%b want 0/0000", inflight, rsp_vld); end
   endtask

   task automatic test_fairness;
      int g;
      logic [N-1:0] e;
      do_reset;
      req_vld = 4'hF;
      for (int c = 0; c < 16; c++) begin
         g = RR ? (c % 4) : 0;
         sb_vld[c] = 1'b1; sb_id[c] = g;
         #1;
         e = 4'b0001 << g;
         n_vec++; if (req_rdy !== e || pipe_in_data !== 8'(8'h10 + g)) begin n_err++; $display("FAIL fair_grant c=%0d got %b/%h want %b/%h", c, req_rdy, pipe_in_data, e, 8'(8'h10 + g)); end
         e = (c >= LAT) ? (4'b0001 << sb_id[c-LAT]) : 4'b0000;
         n_vec++; if (rsp_vld !== e) begin n_err++; $display("FAIL fair_rsp c=%0d got %b want %b", c, rsp_vld, e); end
         if (c >= LAT) begin
            n_vec++; if (rsp_data !== 8'(8'h10 + sb_id[c-LAT])) begin n_err++; $display("FAIL fair_rsp_data c=%0d got %h want %h", c, rsp_data, 8'(8'h10 + sb_id[c-LAT])); end
         end
         n_vec++; if (inflight !== 4'((c < LAT) ? c : LAT)) begin n_err++; $display("FAIL fair_inflight c=%0d got %0d want %0d", c, inflight, (c < LAT) ? c : LAT); end
         step;
      end
      req_vld = '0;
   endtask

   task automatic test_hold;
      int k;
      int exp_if;
      bit h;
      bit ret;
      logic [N-1:0] e;
      do_reset;
      req_vld = 4'hF;
      k = 0; exp_if = 0;
      for (int c = 0; c < 14; c++) begin
         h = (c >= 6 && c <= 10);
         hold = h;
         sb_vld[c] = !h;
         sb_id[c]  = RR ? (k % 4) : 0;
         #1;
         e = h ? 4'b0000 : (4'b0001 << sb_id[c]);
         n_vec++; if (req_rdy !== e || pipe_in_vld !== !h) begin n_err++; $display("FAIL hold_grant c=%0d got %b/%b want %b/%b", c, req_rdy, pipe_in_vld, e, !h); end
         if (h) begin
            n_vec++; if (pipe_in_data !== 8'h00) begin n_err++; $display("FAIL hold_data c=%0d got %h want 00", c, pipe_in_data); end
         end
         ret = (c >= LAT) && sb_vld[c-LAT];
         e = ret ? (4'b0001 << sb_id[c-LAT]) : 4'b0000;
         n_vec++; if (rsp_vld !== e) begin n_err++; $display("FAIL hold_rsp c=%0d got %b want %b", c, rsp_vld, e); end
         n_vec++; if (inflight !== 4'(exp_if)) begin n_err++; $display("FAIL hold_inflight c=%0d got %0d want %0d", c, inflight, exp_if); end
         exp_if = exp_if + (h ? 0 : 1) - (ret ? 1 : 0);
         if (!h) k++;
         step;
      end
      hold = 1'b0; req_vld = '0;
   endtask

   task automatic test_mismatch;
      do_reset;
      force_vld = 1'b1;
      #1;
      n_vec++; if (rsp_vld !== 4'b0000) begin n_err++; $display("FAIL mm_rsp got %b want 0000", rsp_vld); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mm_err_early got %b want 0", err); end
      step;
      force_vld = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mm_err_sticky c=%0d got %b want 1", c, err); end
         step;
      end
   endtask

   task automatic test_reset_midflight;
      do_reset;
      req_vld = 4'hF;
      for (int c = 0; c < 5; c++) step;
      req_vld = '0;
      #1;
      n_vec++; if (inflight !== 4'd5) begin n_err++; $display("FAIL rmf_pre got %0d want 5", inflight); end
      #1;
      rst = 1'b1;
      #1;
      n_vec++; if (inflight !== 4'd0 || rsp_vld !== 4'b0000 || err !== 1'b0) begin n_err++; $display("FAIL rmf_async got %0d/%b/%b want 0/0000/0", inflight, rsp_vld, err); end
      step; step;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_vec++; if (rsp_vld !== 4'b0000 || inflight !== 4'd0 || err !== 1'b0) begin n_err++; $display("FAIL rmf_quiet c=%0d got %b/%0d/%b want 0000/0/0", c, rsp_vld, inflight, err); end
         step;
      end
      req_vld = 4'hF;
      #1;
      n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL rmf_first_grant got %b want 0001", req_rdy); end
      step;
      req_vld = '0;
   endtask

   task automatic test_simultaneous;
      do_reset;
      req_vld = 4'b0010;
      for (int c = 0; c < 3; c++) step;
      req_vld = '0;
      for (int c = 3; c < LAT; c++) step;
      req_vld = 4'b0010;
      #1;
      n_vec++; if (inflight !== 4'd3) begin n_err++; $display("FAIL sim_pre got %0d want 3", inflight); end
      n_vec++; if (rsp_vld !== 4'b0010 || req_rdy !== 4'b0010 || rsp_data !== 8'h11) begin n_err++; $display("FAIL sim_events got %b/%b/%h want 0010/0010/11", rsp_vld, req_rdy, rsp_data); end
      step;
      req_vld = '0;
      #1;
      n_vec++; if (inflight !== 4'd3) begin n_err++; $display("FAIL sim_post got %0d want 3", inflight); end
   endtask

   initial begin
      test_reset;
      test_single_issue;
      test_fairness;
      test_hold;
      test_mismatch;
      test_reset_midflight;
      test_simultaneous;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_share_arbiter.md
# pipe_share_arbiter

Shares one fixed-latency valid-tagged pipeline, such as a shift register with valid or the pipelined sqrt datapath, between `n_req` requesters. Each cycle the block grants at most one requester and drives the granted payload into the pipeline. In parallel it shifts a requester-ID tag through a shadow shift register matched to the pipeline depth. When the result emerges, the block steers it back to the issuing requester, and it keeps an in-flight count and a sticky error if the pipeline's valid and the shadow tag ever disagree.

## Interface
Parameters:
- `n_req`, 4: number of requesters, ≥2
- `width`, 8: payload width
- `latency`, 8: pipeline depth in cycles, ≥2; must equal the depth of the attached pipeline

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `hold`  in  1  while high, no grants are issued
- `req_vld`  in  n_req  requester i has a transfer
- `req_data`  in  n_req*width  flat; requester i occupies bits [i*width +: width]
- `req_rdy`  out  n_req  one-hot or zero; requester i granted this cycle
- `pipe_in_vld`  out  1  to pipeline `in_vld`
- `pipe_in_data`  out  width  to pipeline `in_data`
- `pipe_out_vld`  in  1  from pipeline `out_vld`
- `pipe_out_data`  in  width  from pipeline `out_data`
- `rsp_vld`  out  n_req  one-hot or zero; result for requester i
- `rsp_data`  out  width  broadcast copy of `pipe_out_data`
- `inflight`  out  $clog2(latency+1)  transfers issued and not yet returned
- `err`  out  1  sticky tag/valid mismatch

## Operation
- **Grant** is combinational from `req_vld`, the priority pointer and `hold`.
  - `req_rdy[i]` = 1 for the first requester with `req_vld` set, scanning from `ptr` upward modulo `n_req`.
  - `req_rdy` = 0 when `hold` = 1 or no request is present.
- **Accept**: acceptance for requester i is `req_vld[i] & req_rdy[i]`.
  - `pipe_in_vld` = any acceptance.
  - `pipe_in_data` = the granted requester's slice.
  - `pipe_in_data` = 0 when there is no acceptance.
- **Shadow tag register**: `latency` stages, each holding {tag_vld, id}.
  - Stage 0 loads {accept, granted id} every cycle.
  - Stages shift unconditionally, in lockstep with the pipeline.
- **Response**:
  - `rsp_vld[id_out]` = `pipe_out_vld & tag_vld_out`.
  - `rsp_data` = `pipe_out_data`.
  - Responses cannot be back-pressured; requesters must sink them.
- **Mismatch**: `err` is set when `pipe_out_vld != tag_vld_out`. It stays set until `rst`. On a mismatch, `rsp_vld` = 0.
- **`inflight`**:
  - +1 on accept; −1 when `tag_vld_out` = 1.
  - Both in the same cycle: unchanged.
  - Never exceeds `latency`; with one issue per cycle it saturates at `latency` under continuous load.
- **Pointer**: after an accept by requester i, `ptr` ← (i+1) mod `n_req`. Otherwise `ptr` is unchanged.
- **Reset** (asynchronous, also mid-operation):
  - `ptr` = 0, all tag_vld = 0, `inflight` = 0, `err` = 0.
  - Combinational outputs then evaluate with the cleared state: `req_rdy` from `ptr` = 0; `rsp_vld` = 0 because the tags are invalid.
  - In-flight transfers are discarded. The pipeline must share `rst`; otherwise `err` fires on stale valids.

## Timing
- Grant is zero-latency: `req_rdy` and `pipe_in_vld` are combinational in the request cycle T.
- The response for a transfer accepted in cycle T appears in cycle T+`latency`, for exactly one cycle.
- Throughput: one transfer per cycle, aggregated across all requesters.
- `inflight` and `err` are registered. They reflect events of cycle T from cycle T+1.
- `hold` takes effect in the same cycle. Tags already in flight continue to drain.

## Configuration
- `PIPE_SHARE_ARB_ROUND_ROBIN_EN`
  - Defined: rotating pointer as described above.
  - Undefined: fixed priority. Requester 0 is highest, the scan always starts at 0, and the `ptr` register is not built.

## Test plan
- **Single issue**: `latency`=8; requester 2 issues `req_data`=0xA5 in cycle 10 → `req_rdy`=4'b0100 in cycle 10, `rsp_vld`=4'b0100 and `rsp_data`=0xA5 in cycle 18, `inflight`=1 during cycles 11–18, 0 from cycle 19.
- **Round-robin fairness**: all four requesters request continuously → grants 0,1,2,3,0,…; responses return in the same order 8 cycles later; `inflight` saturates at 8. With the macro undefined, requester 0 wins every cycle.
- **Hold**: `hold`=1 for cycles 20–24 with all requesting → `req_rdy`=0 and `pipe_in_vld`=0 in cycles 20–24; responses already in flight still arrive; `ptr` is unchanged.
- **Mismatch**: force `pipe_out_vld`=1 while the shadow tag is invalid → `err`=1 from the next cycle and stays set; `rsp_vld`=0 in the mismatch cycle.
- **Reset mid-flight**: 5 transfers in flight, assert `rst` → `inflight`=0, `rsp_vld`=0, no responses delivered afterwards, `err`=0. The next grant after release goes to requester 0.
- **Simultaneous events**: an issue and a return in the same cycle with `inflight`=3 → `inflight` stays 3.
